// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: freezes on D-miss, stalls front end on I-miss/load-use, flushes IF/ID on redirect.
// Zero latency: control outputs are combinational from state and inputs; stall statistics and timeout are registered.
module hazard_ctrl #(
    parameter int CW           = 16,
    parameter int TW           = 8,
    parameter int MISS_TIMEOUT = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    ID_Rs,
    input  logic [4:0]    ID_Rt,
    input  logic          ID_UsesRt,
    input  logic          EX_MemRead,
    input  logic [4:0]    EX_WR_out,
    input  logic          ID_BrTaken,
    input  logic          ID_Jump,
    input  logic          I_miss,
    input  logic          I_ready,
    input  logic          D_miss,
    input  logic          D_ready,
    output logic          PCWrite,
    output logic          IF_ID_Write,
    output logic          IF_ID_Flush,
    output logic          ID_EX_Write,
    output logic          ID_EX_Flush,
    output logic          EX_M_Write,
    output logic          M_WB_Flush,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] lu_cnt,
    output logic          timeout_err
);

    typedef enum logic [1:0] {RUN, ISTALL, DSTALL} state_t;

    state_t        state_q, state_d;
    logic          i_pend_q, i_pend_d;
    logic [CW-1:0] stall_cnt_q, lu_cnt_q;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q;

    logic freeze, front, lu_hit, lu_sel, redir, not_ready;

    always_comb begin
        freeze = (state_q == DSTALL && !D_ready) || (state_q != DSTALL && D_miss);
        front  = !freeze && ((state_q == ISTALL && !I_ready) || (state_q == RUN && I_miss));
        lu_hit = EX_MemRead && (EX_WR_out != 5'd0) &&
                 ((EX_WR_out == ID_Rs) || (ID_UsesRt && EX_WR_out == ID_Rt));
        lu_sel = !freeze && !front && lu_hit;
        redir  = !freeze && !front && !lu_hit && (ID_BrTaken || ID_Jump);
        // "not ready" means a miss is still outstanding in the current stall state
        not_ready = (state_q == ISTALL && !I_ready) || (state_q == DSTALL && !D_ready);
    end

    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Write = 1'b1;
        ID_EX_Flush = 1'b0;
        EX_M_Write  = 1'b1;
        M_WB_Flush  = 1'b0;
        if (!rst) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            EX_M_Write  = 1'b0;
            M_WB_Flush  = 1'b1;
        end else if (freeze) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            EX_M_Write  = 1'b0;
            M_WB_Flush  = 1'b1;
        end else if (front || lu_sel) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end else if (redir) begin
            IF_ID_Flush = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_pend_d = i_pend_q;
        case (state_q)
            RUN: begin
                if (D_miss) begin
                    state_d  = DSTALL;
                    i_pend_d = I_miss;
                end else if (I_miss) begin
                    state_d = ISTALL;
                end
            end
            ISTALL: begin
                if (D_miss) begin
                    state_d  = DSTALL;
                    i_pend_d = !I_ready;
                end else if (I_ready) begin
                    state_d = RUN;
                end
            end
            DSTALL: begin
                // an I-miss parked behind the D-miss resumes as soon as MEM is served
                if (D_ready) begin
                    state_d  = (i_pend_q || I_miss) ? ISTALL : RUN;
                    i_pend_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase

        if (state_d != state_q || state_q == RUN)
            wait_cnt_d = '0;
        else if (wait_cnt_q != {TW{1'b1}})
            wait_cnt_d = wait_cnt_q + 1'b1;
        else
            wait_cnt_d = wait_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            i_pend_q    <= 1'b0;
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_pend_q   <= i_pend_d;
            wait_cnt_q <= wait_cnt_d;
            if (!PCWrite && stall_cnt_q != {CW{1'b1}})
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (lu_sel && lu_cnt_q != {CW{1'b1}})
                lu_cnt_q <= lu_cnt_q + 1'b1;
            if (not_ready && wait_cnt_q == TW'(MISS_TIMEOUT - 1))
                timeout_q <= 1'b1;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign lu_cnt      = lu_cnt_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors queued per driven cycle, compared once sampled.
module tb_hazard_ctrl;

    localparam int CW = 16;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Write, M_WB_Flush}
    localparam logic [6:0] NORM   = 7'b1101010;
    localparam logic [6:0] FREEZE = 7'b0000001;
    localparam logic [6:0] STALL  = 7'b0001110;
    localparam logic [6:0] REDIR  = 7'b1111010;
    localparam logic [6:0] RSTV   = 7'b0010101;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] ID_Rs, ID_Rt, EX_WR_out;
    logic ID_UsesRt, EX_MemRead, ID_BrTaken, ID_Jump;
    logic I_miss, I_ready, D_miss, D_ready;
    logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Write, M_WB_Flush;
    logic [CW-1:0] stall_cnt, lu_cnt;
    logic timeout_err;
    logic [6:0] ctl;

    logic [6:0] exp_q[$];
    logic [6:0] obs_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int m_stall = 0;
    int m_lu = 0;

    hazard_ctrl #(.CW(CW), .TW(8), .MISS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_WR_out(EX_WR_out),
        .ID_BrTaken(ID_BrTaken), .ID_Jump(ID_Jump),
        .I_miss(I_miss), .I_ready(I_ready), .D_miss(D_miss), .D_ready(D_ready),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
        .EX_M_Write(EX_M_Write), .M_WB_Flush(M_WB_Flush),
        .stall_cnt(stall_cnt), .lu_cnt(lu_cnt), .timeout_err(timeout_err)
    );

    assign ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Write, M_WB_Flush};

    always #5 clk = ~clk;

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
        EX_MemRead = 1'b0; EX_WR_out = 5'd0;
        ID_BrTaken = 1'b0; ID_Jump = 1'b0;
        I_miss = 1'b0; I_ready = 1'b0; D_miss = 1'b0; D_ready = 1'b0;
    endtask

    // Queue the expectation, sample at the falling edge, update the counter model, move past the rising edge.
    task automatic tick(input logic [6:0] exp, input bit is_lu);
        exp_q.push_back(exp);
        @(negedge clk);
        obs_q.push_back(ctl);
        if (!rst) begin
            m_stall = 0;
            m_lu = 0;
        end else begin
            if (!exp[6] && m_stall < 65535) m_stall++;
            if (is_lu && m_lu < 65535) m_lu++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e, o;
        rst = 1'b0;
        idle();
        tick(RSTV, 1'b0);
        rst = 1'b1;
        n_chk++;
        if (stall_cnt !== 16'd0 || lu_cnt !== 16'd0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state stall=%0d lu=%0d to=%b want 0/0/0", stall_cnt, lu_cnt, timeout_err);
        end
        tick(NORM, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL reset_ctl got=%b want=%b", o, e); end
        end
    endtask

    task automatic test_load_use();
        logic [6:0] e, o;
        EX_MemRead = 1'b1; EX_WR_out = 5'd8; ID_Rs = 5'd8;
        tick(STALL, 1'b1);
        n_chk++;
        if (lu_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lu_first_cnt lu=%0d stall=%0d want 1/1", lu_cnt, stall_cnt);
        end
        EX_WR_out = 5'd0; ID_Rs = 5'd0;
        tick(NORM, 1'b0);
        EX_WR_out = 5'd8; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_UsesRt = 1'b0;
        tick(NORM, 1'b0);
        ID_UsesRt = 1'b1;
        tick(STALL, 1'b1);
        EX_MemRead = 1'b0;
        tick(NORM, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL load_use_ctl got=%b want=%b", o, e); end
        end
        n_chk++;
        if (lu_cnt !== CW'(m_lu) || stall_cnt !== CW'(m_stall)) begin
            n_fail++; $display("FAIL load_use_cnt lu=%0d stall=%0d want %0d/%0d", lu_cnt, stall_cnt, m_lu, m_stall);
        end
    endtask

    task automatic test_branch();
        logic [6:0] e, o;
        ID_BrTaken = 1'b1;
        tick(REDIR, 1'b0);
        ID_BrTaken = 1'b0; ID_Jump = 1'b1;
        tick(REDIR, 1'b0);
        ID_Jump = 1'b0; ID_BrTaken = 1'b1;
        EX_MemRead = 1'b1; EX_WR_out = 5'd5; ID_Rs = 5'd5;
        tick(STALL, 1'b1);
        idle();
        tick(NORM, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL branch_ctl got=%b want=%b", o, e); end
        end
        n_chk++;
        if (lu_cnt !== CW'(m_lu) || stall_cnt !== CW'(m_stall)) begin
            n_fail++; $display("FAIL branch_cnt lu=%0d stall=%0d want %0d/%0d", lu_cnt, stall_cnt, m_lu, m_stall);
        end
    endtask

    task automatic test_dmiss();
        logic [6:0] e, o;
        int s0;
        s0 = int'(stall_cnt);
        D_miss = 1'b1;
        for (int i = 0; i < 4; i++) tick(FREEZE, 1'b0);
        D_ready = 1'b1;
        tick(NORM, 1'b0);
        idle();
        tick(NORM, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL dmiss_ctl got=%b want=%b", o, e); end
        end
        n_chk++;
        if (int'(stall_cnt) - s0 !== 4) begin
            n_fail++; $display("FAIL dmiss_stall_delta got=%0d want=4", int'(stall_cnt) - s0);
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] e, o;
        I_miss = 1'b1; D_miss = 1'b1;
        for (int i = 0; i < 3; i++) tick(FREEZE, 1'b0);
        D_ready = 1'b1;
        tick(NORM, 1'b0);
        D_ready = 1'b0; D_miss = 1'b0;
        tick(STALL, 1'b0);
        I_ready = 1'b1;
        tick(NORM, 1'b0);
        idle();
        tick(NORM, 1'b0);
        // I-miss arriving first, then a D-miss on top of it
        I_miss = 1'b1;
        tick(STALL, 1'b0);
        D_miss = 1'b1;
        tick(FREEZE, 1'b0);
        D_ready = 1'b1;
        tick(NORM, 1'b0);
        D_ready = 1'b0; D_miss = 1'b0;
        tick(STALL, 1'b0);
        I_ready = 1'b1;
        tick(NORM, 1'b0);
        idle();
        tick(NORM, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL simul_ctl got=%b want=%b", o, e); end
        end
        n_chk++;
        if (stall_cnt !== CW'(m_stall) || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL simul_state stall=%0d to=%b want %0d/0", stall_cnt, timeout_err, m_stall);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] e, o;
        I_miss = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick(STALL, 1'b0);
            if (k == 4 || k == 5) begin
                n_chk++;
                if (timeout_err !== (k == 5)) begin
                    n_fail++; $display("FAIL timeout_edge k=%0d got=%b want=%b", k, timeout_err, (k == 5));
                end
            end
        end
        I_ready = 1'b1;
        tick(NORM, 1'b0);
        idle();
        tick(NORM, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL timeout_ctl got=%b want=%b", o, e); end
        end
        n_chk++;
        if (timeout_err !== 1'b1 || stall_cnt !== CW'(m_stall)) begin
            n_fail++; $display("FAIL timeout_sticky to=%b stall=%0d want 1/%0d", timeout_err, stall_cnt, m_stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [6:0] e, o;
        D_miss = 1'b1;
        tick(FREEZE, 1'b0);
        tick(FREEZE, 1'b0);
        rst = 1'b0;
        tick(RSTV, 1'b0);
        rst = 1'b1;
        n_chk++;
        if (stall_cnt !== 16'd0 || lu_cnt !== 16'd0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state stall=%0d lu=%0d to=%b want 0/0/0", stall_cnt, lu_cnt, timeout_err);
        end
        D_miss = 1'b0;
        tick(NORM, 1'b0);
        ID_Jump = 1'b1;
        tick(REDIR, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL midreset_ctl got=%b want=%b", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e, o;
        EX_MemRead = 1'b1; EX_WR_out = 5'd12; ID_Rt = 5'd12; ID_UsesRt = 1'b1;
        for (int i = 0; i < 3; i++) tick(STALL, 1'b1);
        EX_WR_out = 5'd0; ID_Rt = 5'd0;
        tick(NORM, 1'b0);
        idle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_ctl got=%b want=%b", o, e); end
        end
        n_chk++;
        if (lu_cnt !== 16'd3 || stall_cnt !== CW'(m_stall)) begin
            n_fail++; $display("FAIL b2b_cnt lu=%0d stall=%0d want 3/%0d", lu_cnt, stall_cnt, m_stall);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_dmiss();
        test_simultaneous();
        test_timeout();
        test_reset_mid_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
